// File: rtl/spi_master_param.sv
// SPI master with runtime-selectable mode (CPOL/CPHA), parameterised word
// width, SCLK divider and chip-select timing. Everything runs on i_clock; SCLK
// is a registered output that toggles on divider ticks, never a derived clock.
//
// Host handshake: a transfer is accepted on a cycle where the block is idle
// (o_busy low), i_enable is high and i_start is high; i_mode and i_tx_data are
// latched in that cycle. i_start while busy is dropped, not queued. Completion
// is a single-cycle o_done pulse, and o_rx_data changes only in that cycle.
module spi_master_param #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 25,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 1,
    parameter int CS_GAP     = 2,
    parameter int LSB_FIRST  = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_start,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sclk,
    output logic                  o_mosi,
    input  logic                  i_miso,
    output logic                  o_cs_n
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = 16;
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * DATA_WIDTH - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  miso_q;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  tick;
    logic                  leading;
    logic                  sample;
    logic                  do_shift;
    logic [DATA_WIDTH-1:0] tx_next;
    logic [DATA_WIDTH-1:0] rx_next;

    // Bit that goes on the wire first for a given word.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
    endfunction

    assign tick = (div_q == DIV_LAST);

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and next values of all registered outputs and datapath.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        tx_d     = tx_q;
        rx_sh_d  = rx_sh_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        done_d   = 1'b0;
        // cnt_q counts SHIFT ticks from 0, so edge number is cnt_q+1: even cnt = leading.
        leading  = ~cnt_q[0];
        sample   = leading ^ mode_q[0];
        // CPHA=1 presents bit 0 on edge 1 (already driven), CPHA=0 holds the last bit.
        do_shift = mode_q[0] ? (leading && (cnt_q != '0))
                             : (!leading && (cnt_q != SHIFT_LAST));
        tx_next  = (LSB_FIRST != 0) ? (tx_q >> 1) : (tx_q << 1);
        rx_next  = (LSB_FIRST != 0) ? {miso_q, rx_sh_q[DATA_WIDTH-1:1]}
                                    : {rx_sh_q[DATA_WIDTH-2:0], miso_q};

        if (state_q inside {SETUP, SHIFT, HOLD, GAP}) begin
            div_d = tick ? '0 : div_q + DW'(1);
        end

        unique case (state_q)
            IDLE: begin
                div_d = '0;
                cnt_d = '0;
                if (i_enable && i_start) begin
                    state_d = SETUP;
                    mode_d  = i_mode;
                    tx_d    = i_tx_data;
                    rx_sh_d = '0;
                    cs_n_d  = 1'b0;
                    sclk_d  = i_mode[1];
                    mosi_d  = first_bit(i_tx_data);
                end
            end
            SETUP: begin
                if (tick) begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (sample) rx_sh_d = rx_next;
                    if (do_shift) begin
                        tx_d   = tx_next;
                        mosi_d = first_bit(tx_next);
                    end
                    if (cnt_q == SHIFT_LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = GAP;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        sclk_d  = mode_q[1];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                        rx_d    = rx_sh_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                div_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers; reset aborts any transfer silently.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            div_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            miso_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            miso_q  <= i_miso;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_rx_data = rx_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_sclk    = sclk_q;
    assign o_mosi    = mosi_q;
    assign o_cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: an MSB-first instance talking to a behavioural
// SPI slave (or looped back), plus an LSB-first instance in loopback.
`timescale 1ns/1ps
module tb_spi_master_param;

    localparam int W      = 16;
    localparam int D      = 4;
    localparam int S      = 2;
    localparam int H      = 1;
    localparam int G      = 2;
    localparam int LAT    = (S + 2*W + H + G) * D + 1;
    localparam int CS_LOW = (S + 2*W + H) * D;
    localparam int LIMIT  = 2000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         en = 1'b0, start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] tx = '0;
    logic [W-1:0] rx;
    logic         busy, done, sclk, mosi, miso, cs_n;

    logic         l_en = 1'b0, l_start = 1'b0;
    logic [1:0]   l_mode = 2'b00;
    logic [W-1:0] l_tx = '0;
    logic [W-1:0] l_rx;
    logic         l_busy, l_done, l_sclk, l_mosi, l_cs_n;

    spi_master_param #(.DATA_WIDTH(W), .CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H),
                       .CS_GAP(G), .LSB_FIRST(0)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_start(start),
        .i_mode(mode), .i_tx_data(tx), .o_rx_data(rx), .o_busy(busy),
        .o_done(done), .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso),
        .o_cs_n(cs_n)
    );

    spi_master_param #(.DATA_WIDTH(W), .CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H),
                       .CS_GAP(G), .LSB_FIRST(1)) u_lsb (
        .i_clock(clk), .i_reset(rst), .i_enable(l_en), .i_start(l_start),
        .i_mode(l_mode), .i_tx_data(l_tx), .o_rx_data(l_rx), .o_busy(l_busy),
        .o_done(l_done), .o_sclk(l_sclk), .o_mosi(l_mosi), .i_miso(l_mosi),
        .o_cs_n(l_cs_n)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // ---------------- behavioural slave + bus monitor ----------------
    logic [1:0]   cur_mode   = 2'b00;
    logic [W-1:0] slave_word = '0;
    logic         loopback   = 1'b0;
    logic         slave_miso = 1'b0;
    logic [W-1:0] slave_rx = '0, slave_rx_last = '0;
    logic         prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    int edge_n = 0, rises = 0, rises_last = 0;
    int cs_cnt = 0, cs_len_last = 0, high_cnt = 0, gap_last = 0;
    int bad_mosi = 0;

    assign miso = loopback ? mosi : slave_miso;

    always @(negedge clk) begin
        bit edge_now;
        bit samp;
        int idx;
        edge_now = 1'b0;
        samp     = 1'b0;
        if (prev_cs && !cs_n) begin
            edge_n     = 0;
            rises      = 0;
            cs_cnt     = 1;
            slave_rx   = '0;
            gap_last   = high_cnt;
            slave_miso = cur_mode[0] ? 1'b0 : slave_word[W-1];
        end else if (!cs_n) begin
            cs_cnt++;
            if (sclk != prev_sclk) begin
                edge_now = 1'b1;
                edge_n++;
                if (sclk) rises++;
                // odd edges lead; CPHA=0 samples leading, CPHA=1 samples trailing
                samp = ((edge_n % 2) == 1) ^ cur_mode[0];
                if (samp) begin
                    slave_rx = {slave_rx[W-2:0], mosi};
                end else begin
                    idx = cur_mode[0] ? (edge_n - 1) / 2 : edge_n / 2;
                    if (idx < W) slave_miso = slave_word[W-1-idx];
                end
            end
            if (mosi != prev_mosi) begin
                if (!edge_now || samp || edge_n == 2*W) bad_mosi++;
            end
        end else begin
            if (!prev_cs) begin
                cs_len_last   = cs_cnt;
                rises_last    = rises;
                slave_rx_last = slave_rx;
                high_cnt      = 1;
            end else begin
                high_cnt++;
            end
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
    end

    // LSB-first instance: collect MOSI on rising SCLK (mode 0), LSB arrives first.
    logic [W-1:0] l_word = '0;
    logic         l_prev_cs = 1'b1, l_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (l_prev_cs && !l_cs_n)                  l_word = '0;
        else if (!l_cs_n && l_sclk && !l_prev_sclk) l_word = {l_mosi, l_word[W-1:1]};
        l_prev_cs   = l_cs_n;
        l_prev_sclk = l_sclk;
    end

    // ---------------- driver tasks ----------------
    task automatic run_xfer(input logic [1:0] m, input logic [W-1:0] t, input logic [W-1:0] sw,
                            input bit lb, input bit drop_en, input bit pulse);
        logic [W-1:0] want;
        int k;
        int act;
        cur_mode   = m;
        slave_word = sw;
        loopback   = lb;
        exp_q.push_back(lb ? t : sw);
        @(negedge clk);
        en = 1'b1; start = 1'b1; mode = m; tx = t;
        @(negedge clk);
        start = 1'b0;
        if (drop_en) en = 1'b0;
        chk("acc_busy", busy, 1);
        chk("acc_cs_n", cs_n, 0);
        chk("acc_sclk", sclk, m[1]);
        chk("acc_mosi", mosi, t[W-1]);
        k = 1;
        while (!done && k < LIMIT) begin
            @(negedge clk);
            k++;
            start = pulse && (k == 10);
        end
        want = exp_q.pop_front();
        chk("done_latency", k, LAT);
        chk("rx_word", rx, want);
        chk("slave_got_tx", slave_rx_last, t);
        chk("sclk_rises", rises_last, W);
        chk("cs_low_cycles", cs_len_last, CS_LOW);
        chk("mosi_timing", bad_mosi, 0);
        if (pulse) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_width", done, 0);
        chk("rx_stable", rx, want);
        chk("sclk_idle", sclk, m[1]);
        chk("mosi_idle", mosi, 0);
        chk("idle_busy", busy, 0);
        if (pulse) begin
            act = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy || !cs_n) act++;
            end
            chk("start_ignored", act, 0);
        end
        en = 1'b1;
    endtask

    task automatic lsb_xfer(input logic [W-1:0] t);
        int k;
        @(negedge clk);
        l_en = 1'b1; l_start = 1'b1; l_mode = 2'b00; l_tx = t;
        @(negedge clk);
        l_start = 1'b0;
        chk("lsb_first_bit", l_mosi, t[0]);
        k = 1;
        while (!l_done && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        chk("lsb_latency", k, LAT);
        chk("lsb_rx", l_rx, t);
        chk("lsb_wire_order", l_word, t);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int k;
        int act;
        bit seen_done;
        logic [W-1:0] w1, w2;

        // reset values
        #12;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // mode 0 loopback
        run_xfer(2'b00, 16'h8A5C, 16'h0000, 1'b1, 1'b0, 1'b0);

        // mode 3 with slave, then mode 0 back to idle-low SCLK
        run_xfer(2'b11, 16'h00FF, 16'hC3A5, 1'b0, 1'b0, 1'b0);
        run_xfer(2'b00, 16'h1234, 16'h5A0F, 1'b0, 1'b0, 1'b0);

        // stray start pulses mid-transfer and on the done cycle
        run_xfer(2'b10, 16'hF00D, 16'h7E81, 1'b0, 1'b0, 1'b1);

        // level-high start: back-to-back transfers
        w1 = W'($urandom);
        w2 = W'($urandom);
        cur_mode = 2'b01; slave_word = w1; loopback = 1'b0;
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        @(negedge clk);
        en = 1'b1; start = 1'b1; mode = 2'b01; tx = 16'hA55A;
        k = 0;
        while (!done && k < LIMIT) begin @(negedge clk); k++; end
        chk("b2b_rx1", rx, exp_q.pop_front());
        slave_word = w2;
        k = 0;
        while (k == 0 || (!done && k < LIMIT)) begin @(negedge clk); k++; end
        start = 1'b0;
        chk("b2b_spacing", k, LAT + 1);
        chk("b2b_rx2", rx, exp_q.pop_front());
        chk("b2b_gap_ok", gap_last >= G*D, 1);
        @(negedge clk);

        // reset while SHIFT edge 7 is on the bus
        cur_mode = 2'b01; slave_word = 16'hBEEF; loopback = 1'b0;
        @(negedge clk);
        en = 1'b1; start = 1'b1; mode = 2'b01; tx = W'($urandom);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(edge_n == 7 && !cs_n) && k < LIMIT) begin @(negedge clk); k++; end
        chk("rst_edge7_reached", k < LIMIT, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rx", rx, 0);
        chk("abort_mosi", mosi, 0);
        seen_done = 1'b0;
        repeat (3) begin @(negedge clk); if (done) seen_done = 1'b1; end
        rst = 1'b0;
        repeat (20) begin @(negedge clk); if (done) seen_done = 1'b1; end
        chk("abort_no_done", seen_done, 0);
        run_xfer(2'b01, 16'h3C96, 16'h9669, 1'b0, 1'b0, 1'b0);

        // enable low blocks acceptance
        @(negedge clk);
        en = 1'b0; start = 1'b1;
        act = 0;
        repeat (30) begin @(negedge clk); if (busy || !cs_n || done) act++; end
        start = 1'b0;
        chk("en_off_idle", act, 0);

        // LSB-first instance
        lsb_xfer(16'h0001);
        lsb_xfer(W'($urandom));
        lsb_xfer(W'($urandom));

        // randomized modes/data, with enable sometimes dropped mid-transfer
        for (int i = 0; i < 6; i++) begin
            run_xfer(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
